// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port and the valid/ready output stream.
// master: the read-side consumer; slave: FIFO side plus downstream sink.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic                  fifo_re;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [OCC_W-1:0]      occupancy;
    logic [CNT_WIDTH-1:0]  pkt_count;

    modport master (
        output fifo_re,
        input  fifo_empty,
        input  fifo_dout,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
        output occupancy,
        output pkt_count
    );

    modport slave (
        input  fifo_re,
        output fifo_empty,
        output fifo_dout,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  occupancy,
        input  pkt_count
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: prefetch buffer feeding a valid/ready stream,
// with packet delimiting every PKT_LEN beats and a completed-packet count.
// Ports: rclk, r_rst (sync, active-high), flush, bus (FIFO read + stream).
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic             rclk,
    input  logic             r_rst,
    input  logic             flush,
    fifo_rd_stream_if.master bus
);
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);
    localparam logic [OCC_W:0]    DEPTH     = (OCC_W + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 infl_q, infl_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] pkt_q, pkt_d;

    logic             valid;
    logic             last;
    logic             issue;
    logic             push;
    logic             pop;
    logic [OCC_W:0]   pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // An in-flight word already owns a buffer slot, so overflow cannot occur.
        pending = {1'b0, occ_q} + {{OCC_W{1'b0}}, infl_q};
        issue   = !r_rst && !flush && !bus.fifo_empty && (pending < DEPTH);
        valid   = (occ_q != '0) && !r_rst;
        last    = valid && (beat_q == BEAT_LAST);
        push    = infl_q;
        pop     = valid && bus.out_ready;

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        infl_d = issue;
        beat_d = beat_q;
        pkt_d  = pkt_q;

        if (r_rst) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            beat_d = '0;
            pkt_d  = '0;
        end else if (flush) begin
            // Clearing infl_q drops the word still arriving on fifo_dout.
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            beat_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
                beat_d = last ? '0 : beat_q + 1'b1;
                if (last) begin
                    pkt_d = pkt_q + 1'b1;
                end
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (r_rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            infl_q <= 1'b0;
            beat_q <= '0;
            pkt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            infl_q <= infl_d;
            beat_q <= beat_d;
            pkt_q  <= pkt_d;
        end
    end

    // Storage needs no reset; occupancy alone says which entries are live.
    always_ff @(posedge rclk) begin
        if (push && !r_rst && !flush) begin
            mem_q[tail_q] <= bus.fifo_dout;
        end
    end

    assign bus.fifo_re   = issue;
    assign bus.out_data  = mem_q[head_q];
    assign bus.out_valid = valid;
    assign bus.out_last  = last;
    assign bus.occupancy = occ_q;
    assign bus.pkt_count = pkt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO on the read port,
// negedge monitor logging beats and pops, hand-computed expectations.
module tb_fifo_rd_stream;
    logic rclk = 1'b0;
    logic r_rst;
    logic flush;

    always #5 rclk = ~rclk;

    fifo_rd_stream_if #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(16)) ifc ();

    fifo_rd_stream #(
        .DATA_WIDTH(8),
        .BUF_DEPTH (3),
        .PKT_LEN   (4),
        .CNT_WIDTH (16)
    ) dut (
        .rclk (rclk),
        .r_rst(r_rst),
        .flush(flush),
        .bus  (ifc.master)
    );

    // Behavioural FIFO: one-cycle read latency.
    logic [7:0] fmem [256];
    int wr_n = 0;
    int rd_n = 0;

    assign ifc.fifo_empty = (wr_n == rd_n);

    always @(posedge rclk) begin
        if (ifc.fifo_re) begin
            ifc.fifo_dout <= fmem[rd_n[7:0]];
            rd_n          <= rd_n + 1;
        end
    end

    // Monitor
    int         cyc = 0;
    int         got_n = 0;
    int         re_n = 0;
    int         bad_re = 0;
    int         stall_err = 0;
    logic [7:0] got_d [64];
    logic       got_l [64];
    int         got_c [64];
    int         re_c  [64];
    logic       pv = 1'b0;
    logic       prdy = 1'b0;
    logic       pflr = 1'b1;
    logic [7:0] pd = '0;
    logic       pl = 1'b0;

    always @(negedge rclk) begin
        cyc = cyc + 1;
        if (!r_rst && !flush && ifc.out_valid && ifc.out_ready) begin
            got_d[got_n] = ifc.out_data;
            got_l[got_n] = ifc.out_last;
            got_c[got_n] = cyc;
            got_n = got_n + 1;
        end
        if (ifc.fifo_re) begin
            re_c[re_n] = cyc;
            re_n = re_n + 1;
            if (ifc.fifo_empty) bad_re = bad_re + 1;
        end
        if (pv && !prdy && !pflr) begin
            if (!(ifc.out_valid && ifc.out_data == pd && ifc.out_last == pl))
                stall_err = stall_err + 1;
        end
        pv   = ifc.out_valid;
        prdy = ifc.out_ready;
        pflr = r_rst || flush;
        pd   = ifc.out_data;
        pl   = ifc.out_last;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic smp();
        @(negedge rclk);
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_n[7:0]] = d;
        wr_n = wr_n + 1;
    endtask

    int bg;
    int br;

    initial begin
        r_rst         = 1'b1;
        flush         = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.fifo_dout = '0;
        push(8'h11);

        // Reset with a non-empty FIFO
        repeat (3) begin
            smp();
            chk("rst_re", ifc.fifo_re, 0);
            tick();
        end
        r_rst = 1'b0;
        smp();
        chk("rel_re", ifc.fifo_re, 1);
        chk("rel_valid", ifc.out_valid, 0);
        chk("rel_occ", ifc.occupancy, 0);
        chk("rel_pkt", ifc.pkt_count, 0);
        tick();
        r_rst = 1'b1;
        wr_n  = rd_n;
        tick();
        r_rst = 1'b0;
        smp();
        chk("rst_drop_valid", ifc.out_valid, 0);
        chk("rst_drop_occ", ifc.occupancy, 0);
        tick();

        // Single word: pop at t, valid at t+2
        ifc.out_ready = 1'b1;
        push(8'hA5);
        smp();
        chk("single_re", ifc.fifo_re, 1);
        tick();
        smp();
        chk("single_re_off", ifc.fifo_re, 0);
        chk("single_t1_valid", ifc.out_valid, 0);
        tick();
        smp();
        chk("single_t2_valid", ifc.out_valid, 1);
        chk("single_data", ifc.out_data, 8'hA5);
        tick();
        smp();
        chk("single_occ", ifc.occupancy, 0);
        tick();

        // Streaming 8 words
        bg = got_n;
        br = re_n;
        for (int i = 0; i < 8; i++) push(8'(i + 1));
        repeat (14) tick();
        chk("stream_pops", re_n - br, 8);
        chk("stream_re_run", re_c[br + 7] - re_c[br], 7);
        chk("stream_beats", got_n - bg, 8);
        for (int k = 0; k < 8; k++) chk("stream_data", got_d[bg + k], k + 1);
        chk("stream_bubbles", got_c[bg + 7] - got_c[bg], 7);

        // Backpressure: 10 queued, sink stalled
        ifc.out_ready = 1'b0;
        bg = got_n;
        br = re_n;
        for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
        repeat (6) tick();
        smp();
        chk("bp_pops", re_n - br, 3);
        chk("bp_occ", ifc.occupancy, 3);
        chk("bp_re", ifc.fifo_re, 0);
        chk("bp_data", ifc.out_data, 8'h20);
        tick();
        smp();
        chk("bp_hold", ifc.out_data, 8'h20);
        tick();
        ifc.out_ready = 1'b1;
        repeat (16) tick();
        chk("bp_beats", got_n - bg, 10);
        for (int k = 0; k < 10; k++) chk("bp_order", got_d[bg + k], 8'h20 + k);
        // 1 + 8 + 10 = 19 beats -> 4 full packets
        chk("bp_pkt", ifc.pkt_count, 4);

        // Packets under random backpressure, starting from a flushed state
        ifc.out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        smp();
        chk("flush_keep_pkt", ifc.pkt_count, 4);
        tick();
        bg = got_n;
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        for (int i = 0; i < 40; i++) begin
            ifc.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        ifc.out_ready = 1'b1;
        repeat (12) tick();
        chk("pkt_beats", got_n - bg, 8);
        for (int k = 0; k < 8; k++) begin
            chk("pkt_data", got_d[bg + k], 8'h30 + k);
            chk("pkt_last", got_l[bg + k], (k == 3 || k == 7) ? 1 : 0);
        end
        chk("pkt_count", ifc.pkt_count, 6);
        chk("stall_stable", stall_err, 0);

        // Flush mid-packet with occupancy 2 and one word in flight
        push(8'h3F);
        repeat (4) tick();
        ifc.out_ready = 1'b0;
        push(8'h40);
        push(8'h41);
        push(8'h42);
        smp();
        chk("fl_re_t0", ifc.fifo_re, 1);
        tick();
        tick();
        tick();
        smp();
        chk("fl_occ2", ifc.occupancy, 2);
        chk("fl_re_t3", ifc.fifo_re, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        smp();
        chk("fl_valid", ifc.out_valid, 0);
        chk("fl_occ0", ifc.occupancy, 0);
        bg = got_n;
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        ifc.out_ready = 1'b1;
        repeat (10) tick();
        chk("fl_beats", got_n - bg, 4);
        for (int k = 0; k < 4; k++) begin
            chk("fl_data", got_d[bg + k], 8'h50 + k);
            chk("fl_last", got_l[bg + k], (k == 3) ? 1 : 0);
        end
        chk("fl_pkt", ifc.pkt_count, 7);
        chk("no_re_empty", bad_re, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
